// File: rtl/apb_regfile_slave.sv
// APB4 register-file slave: NUM_REGS word registers (RW or hardware-status RO),
// byte strobes, programmable wait states, PSLVERR and per-register write pulses.
module apb_regfile_slave #(
    parameter int unsigned            ADDR_WIDTH  = 8,
    parameter int unsigned            DATA_WIDTH  = 32,
    parameter int unsigned            NUM_REGS    = 8,
    parameter int unsigned            WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]    RO_MASK     = '0
) (
    input  logic                           PCLK,
    input  logic                           PRESETn,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned NBYTES = DATA_WIDTH / 8;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

    logic [IDX_W-1:0]       idx;
    logic                   idx_ok;
    logic                   ro_hit;
    logic                   addr_err;
    logic                   ro_err;
    logic                   err;
    logic                   complete;
    logic                   wr_commit;
    logic [DATA_WIDTH-1:0]  rd_data;

    assign idx      = PADDR[ADDR_WIDTH-1:2];
    assign idx_ok   = {1'b0, idx} < (IDX_W+1)'(NUM_REGS);
    assign addr_err = (PADDR[1:0] != 2'b00) || !idx_ok;
    assign ro_err   = PWRITE && ro_hit && !addr_err;
    assign err      = addr_err || ro_err;

    assign complete  = (state == ACCESS) && PSEL && PENABLE && (cnt == '0);
    assign wr_commit = complete && PWRITE && !err;

    // Register-select mux; RO slots read straight from hardware status
    always_comb begin
        ro_hit  = 1'b0;
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                ro_hit  = RO_MASK[i];
                rd_data = RO_MASK[i] ? hw_status[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
            end
        end
    end

    assign PREADY  = (state == IDLE) || (cnt == '0);
    assign PRDATA  = (complete && !PWRITE && !err) ? rd_data : '0;
    assign PSLVERR = complete && err;

    // Transfer FSM with wait-state counter
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        state <= ACCESS;
                        cnt   <= CNT_W'(WAIT_STATES);
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (!PENABLE) begin
                        cnt <= CNT_W'(WAIT_STATES);
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Byte-lane register writes and one-cycle commit pulses
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            wr_pulse <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                wr_pulse[i] <= wr_commit && (idx == IDX_W'(i));
                for (int unsigned b = 0; b < NBYTES; b++) begin
                    if (wr_commit && !RO_MASK[i] && (idx == IDX_W'(i)) && PSTRB[b])
                        regs[i][8*b +: 8] <= PWDATA[8*b +: 8];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? '0 : regs[g];
    end

    // hw_status slots of RW registers are intentionally ignored
    logic unused_hw;
    assign unused_hw = ^hw_status;

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomised self-checking bench for apb_regfile_slave against a register-array model.
module tb_apb_regfile_slave;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 6;
    localparam int unsigned WS = 2;
    localparam logic [NR-1:0] RO = 6'b100001;

    logic              PCLK = 1'b0;
    logic              PRESETn;
    logic              PSEL, PENABLE, PWRITE;
    logic [AW-1:0]     PADDR;
    logic [DW-1:0]     PWDATA;
    logic [DW/8-1:0]   PSTRB;
    logic [DW-1:0]     PRDATA;
    logic              PREADY, PSLVERR;
    logic [NR*DW-1:0]  hw_status;
    logic [NR*DW-1:0]  reg_out;
    logic [NR-1:0]     wr_pulse;

    apb_regfile_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR), .WAIT_STATES(WS), .RO_MASK(RO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .hw_status(hw_status), .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mdl [NR];
    logic [NR-1:0] exp_pulse;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR*DW-1:0] exp_regout();
        logic [NR*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? '0 : mdl[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        exp_pulse = '0;
    endtask

    // One APB transfer; returns at posedge+1 after completion with PSEL still high
    task automatic xfer(input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
        int            idx;
        bit            e;
        bit            done;
        int            waits;
        logic [DW-1:0] exp_rd;
        idx = int'(addr[AW-1:2]);
        e   = (addr[1:0] != 2'b00) || (idx >= NR);
        if (!e && wr && RO[idx]) e = 1'b1;
        exp_rd = '0;
        if (!wr && !e) exp_rd = RO[idx] ? hw_status[idx*DW +: DW] : mdl[idx];

        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
        @(negedge PCLK);
        check_eq("setup_pready", PREADY, 1);
        check_eq("setup_prdata", PRDATA, 0);
        check_eq("wr_pulse", wr_pulse, exp_pulse);
        check_eq("reg_out", reg_out, exp_regout());
        exp_pulse = '0;
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge PCLK);
            if (PREADY === 1'b1) begin
                done = 1'b1;
            end else begin
                check_eq("wait_prdata", PRDATA, 0);
                check_eq("wait_pslverr", PSLVERR, 0);
                waits++;
                if (waits > 20) begin
                    check_eq("pready_timeout", 1, 0);
                    done = 1'b1;
                end else begin
                    @(posedge PCLK) #1;
                end
            end
        end
        check_eq("wait_count", waits, WS);
        check_eq("pslverr", PSLVERR, e);
        check_eq("prdata", PRDATA, exp_rd);
        if (wr && !e) begin
            for (int b = 0; b < DW/8; b++)
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            exp_pulse = NR'(1) << idx;
        end
        @(posedge PCLK) #1;
    endtask

    task automatic idle();
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        check_eq("idle_pready", PREADY, 1);
        check_eq("idle_prdata", PRDATA, 0);
        check_eq("idle_pslverr", PSLVERR, 0);
        check_eq("wr_pulse", wr_pulse, exp_pulse);
        check_eq("reg_out", reg_out, exp_regout());
        exp_pulse = '0;
        @(posedge PCLK) #1;
    endtask

    // Write abandoned on its 2nd ACCESS cycle, by PSEL drop or by reset
    task automatic abort_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit use_reset);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PSTRB = '1;
        @(posedge PCLK) #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        check_eq("abort_wait1", PREADY, 0);
        @(posedge PCLK) #1;
        if (use_reset) begin
            PRESETn = 1'b0;
            model_reset();
            @(negedge PCLK);
            check_eq("rst_pready", PREADY, 1);
            check_eq("rst_reg_out", reg_out, 0);
            check_eq("rst_pulse", wr_pulse, 0);
            PSEL = 1'b0; PENABLE = 1'b0;
            @(posedge PCLK) #1;
            PRESETn = 1'b1;
        end else begin
            PSEL = 1'b0; PENABLE = 1'b0;
            @(negedge PCLK);
            check_eq("abort_pslverr", PSLVERR, 0);
            @(posedge PCLK) #1;
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            r;
        PRESETn = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0; PSTRB = '0;
        for (int i = 0; i < NR; i++) hw_status[i*DW +: DW] = $urandom;
        hw_status[0 +: DW] = 32'hCAFE0001;
        model_reset();
        @(negedge PCLK);
        check_eq("rst_pready", PREADY, 1);
        check_eq("rst_prdata", PRDATA, 0);
        check_eq("rst_pslverr", PSLVERR, 0);
        check_eq("rst_pulse", wr_pulse, 0);
        check_eq("rst_reg_out", reg_out, 0);
        @(posedge PCLK) #1;
        PRESETn = 1'b1;

        xfer(1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
        idle();
        idle();
        xfer(1'b0, 8'h04, 32'h0, 4'h0);
        idle();

        xfer(1'b1, 8'h08, 32'h11223344, 4'hF);
        xfer(1'b1, 8'h08, 32'hAABBCCDD, 4'h5);
        xfer(1'b0, 8'h08, 32'h0, 4'hF);
        idle();
        check_eq("strb_merge", reg_out[2*DW +: DW], 32'h11BB33DD);

        xfer(1'b1, 8'h00, 32'h12345678, 4'hF);
        xfer(1'b0, 8'h00, 32'h0, 4'h0);
        idle();

        xfer(1'b0, 8'h20, 32'h0, 4'h0);
        xfer(1'b1, 8'h06, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 8'h18, 32'hFFFFFFFF, 4'hF);
        xfer(1'b1, 8'h0C, 32'h0BADF00D, 4'h0);
        idle();

        xfer(1'b1, 8'h0C, 32'h55AA55AA, 4'hF);
        idle();
        abort_write(8'h0C, 32'h12345678, 1'b0);
        abort_write(8'h10, 32'h87654321, 1'b1);

        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 7)       a = {AW'($urandom_range(0, 7)) << 2};
            else if (r == 7) a = AW'($urandom);
            else             a = {AW'($urandom_range(0, 5)) << 2};
            xfer(1'($urandom), a, $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                hw_status[$urandom_range(0, NR-1)*DW +: DW] = $urandom;
                idle();
            end
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
